jtframe_vtimer: RTL and testbench

JTFRAME_VTIMER -- requirements
Module: jtframe_vtimer

---
 rtl/jtframe_video_pkg.sv | 35 +++
 rtl/jtframe_wrapcnt.sv | 39 +++
 rtl/jtframe_vtimer.sv | 111 +++++++++++
 tb/tb_jtframe_vtimer.sv | 251 +++++++++++++++++++++++++
 4 files changed

// File: rtl/jtframe_video_pkg.sv
// Shared video timing constants and 9-bit counter helpers for the timer, line doubler and cores.
// Latency: none (constants and pure functions only).
// Backpressure: not applicable.
package jtframe_video_pkg;

    // Default 384x264 raster: 256x224 visible area.
    localparam int VT_HCNT_START = 0;
    localparam int VT_HCNT_END   = 383;
    localparam int VT_HB_START   = 256;
    localparam int VT_HB_END     = 0;
    localparam int VT_HS_START   = 288;
    localparam int VT_HS_END     = 320;
    localparam int VT_VCNT_START = 0;
    localparam int VT_VCNT_END   = 263;
    localparam int VT_VB_START   = 240;
    localparam int VT_VB_END     = 16;
    localparam int VT_VS_START   = 248;
    localparam int VT_VS_END     = 251;

    typedef logic [8:0] cnt9_t;

    // Half-open window [s, e); when s > e the window wraps past the counter end.
    function automatic logic in_span(cnt9_t v, cnt9_t s, cnt9_t e);
        if (s <= e) begin
            return (v >= s) && (v < e);
        end
        return (v >= s) || (v < e);
    endfunction

    // Successor of v on a counter running s..e.
    function automatic cnt9_t wrap_inc(cnt9_t v, cnt9_t s, cnt9_t e);
        return (v == e) ? s : v + 9'd1;
    endfunction

endpackage

// File: rtl/jtframe_wrapcnt.sv
// 9-bit counter running CNT_START..CNT_END, advancing on en, with an end-of-range flag.
// Latency: cnt updates one clk after en; cnt_nxt is the combinational value cnt will take.
// Backpressure: none; en low holds the count indefinitely.
module jtframe_wrapcnt
    import jtframe_video_pkg::*;
#(
    parameter int CNT_START = 0,
    parameter int CNT_END   = 383
) (
    input  logic  clk,
    input  logic  rst_n,
    input  logic  en,
    output cnt9_t cnt,
    output cnt9_t cnt_nxt,
    output logic  wrap
);
    localparam cnt9_t START9 = cnt9_t'(CNT_START);
    localparam cnt9_t END9   = cnt9_t'(CNT_END);

    assign wrap = (cnt == END9);

    // Next count: hold when disabled, otherwise step and wrap at the end value.
    always_comb begin
        cnt_nxt = cnt;
        if (en) begin
            cnt_nxt = wrap ? START9 : cnt + 9'd1;
        end
    end

    // Count register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= START9;
        end else begin
            cnt <= cnt_nxt;
        end
    end

endmodule

// File: rtl/jtframe_vtimer.sv
// Video timing generator: H/V counters plus blanking, sync and line/frame strobes.
// Latency: every output is registered and aligned with the H value of the same cycle.
// Backpressure: none; pxl_cen low freezes all state and outputs.
module jtframe_vtimer
    import jtframe_video_pkg::*;
#(
    parameter int HCNT_START = VT_HCNT_START,
    parameter int HCNT_END   = VT_HCNT_END,
    parameter int HB_START   = VT_HB_START,
    parameter int HB_END     = VT_HB_END,
    parameter int HS_START   = VT_HS_START,
    parameter int HS_END     = VT_HS_END,
    parameter int VCNT_START = VT_VCNT_START,
    parameter int VCNT_END   = VT_VCNT_END,
    parameter int VB_START   = VT_VB_START,
    parameter int VB_END     = VT_VB_END,
    parameter int VS_START   = VT_VS_START,
    parameter int VS_END     = VT_VS_END
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       pxl_cen,
    output logic [8:0] H,
    output logic [8:0] vdump,
    output logic [8:0] vrender,
    output logic [8:0] vrender1,
    output logic       Hinit,
    output logic       Vinit,
    output logic       LHBL,
    output logic       LVBL,
    output logic       HS,
    output logic       VS
);
    // Parameter sanity: counters are 9 bits, lines need at least two pixels, HS at least two pixels wide.
    if (HCNT_START > 511 || HCNT_END > 511 || HB_START > 511 || HB_END > 511 ||
        HS_START > 511 || HS_END > 511 || VCNT_START > 511 || VCNT_END > 511 ||
        VB_START > 511 || VB_END > 511 || VS_START > 511 || VS_END > 511) begin : g_bad_range
        $fatal(1, "jtframe_vtimer: timing parameter above 511");
    end
    if (HCNT_END <= HCNT_START) begin : g_bad_line
        $fatal(1, "jtframe_vtimer: line must be at least two pixels long");
    end
    if (HS_END - HS_START < 2) begin : g_bad_hs
        $fatal(1, "jtframe_vtimer: HS must be at least two pixels wide");
    end

    localparam cnt9_t HE   = cnt9_t'(HCNT_END);
    localparam cnt9_t HBS  = cnt9_t'(HB_START);
    localparam cnt9_t HBE  = cnt9_t'(HB_END);
    localparam cnt9_t HSS  = cnt9_t'(HS_START);
    localparam cnt9_t HSE  = cnt9_t'(HS_END);
    localparam cnt9_t VST  = cnt9_t'(VCNT_START);
    localparam cnt9_t VE   = cnt9_t'(VCNT_END);
    localparam cnt9_t VBS  = cnt9_t'(VB_START);
    localparam cnt9_t VBE  = cnt9_t'(VB_END);
    localparam cnt9_t VSS  = cnt9_t'(VS_START);
    localparam cnt9_t VSE  = cnt9_t'(VS_END);
    localparam cnt9_t VR0  = wrap_inc(VST, VST, VE);
    localparam cnt9_t VR1  = wrap_inc(VR0, VST, VE);

    cnt9_t h_cnt, h_nxt, v_cnt, v_nxt;
    logic  h_wrap, v_wrap;

    jtframe_wrapcnt #(.CNT_START(HCNT_START), .CNT_END(HCNT_END)) u_hcnt (
        .clk     (clk),
        .rst_n   (rst_n),
        .en      (pxl_cen),
        .cnt     (h_cnt),
        .cnt_nxt (h_nxt),
        .wrap    (h_wrap)
    );

    jtframe_wrapcnt #(.CNT_START(VCNT_START), .CNT_END(VCNT_END)) u_vcnt (
        .clk     (clk),
        .rst_n   (rst_n),
        .en      (pxl_cen & h_wrap),
        .cnt     (v_cnt),
        .cnt_nxt (v_nxt),
        .wrap    (v_wrap)
    );

    assign H     = h_cnt;
    assign vdump = v_cnt;

    // Decode from the next counter values so each flag lands together with the H it describes.
    // Vinit uses v_wrap directly: H cannot wrap on the step into HCNT_END, so vdump is unchanged.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vrender  <= VR0;
            vrender1 <= VR1;
            Hinit    <= 1'b0;
            Vinit    <= 1'b0;
            LHBL     <= 1'b0;
            LVBL     <= 1'b0;
            HS       <= 1'b0;
            VS       <= 1'b0;
        end else if (pxl_cen) begin
            vrender  <= wrap_inc(v_nxt, VST, VE);
            vrender1 <= wrap_inc(wrap_inc(v_nxt, VST, VE), VST, VE);
            Hinit    <= (h_nxt == HE);
            Vinit    <= (h_nxt == HE) && v_wrap;
            LHBL     <= !in_span(h_nxt, HBS, HBE);
            HS       <= in_span(h_nxt, HSS, HSE);
            if (h_nxt == HBS) begin
                LVBL <= !in_span(v_nxt, VBS, VBE);
                VS   <= in_span(v_nxt, VSS, VSE);
            end
        end
    end

endmodule

// File: tb/tb_jtframe_vtimer.sv
// Bench for jtframe_vtimer: default raster plus a small offset raster checked against a modular-arithmetic model.
// Latency: model mirrors one update per pxl_cen edge; outputs compared on every falling clk edge.
// Backpressure: pxl_cen randomly gated and held low for long stretches.
module tb_jtframe_vtimer;

    logic clk     = 1'b0;
    logic rst_n   = 1'b0;
    logic pxl_cen = 1'b0;
    logic chk_en  = 1'b0;

    always #5 clk = ~clk;

    // Instance 0: default raster. Instance 1: small raster with non-zero starts and wrapping windows.
    localparam int P_HCS [2] = '{0,   2};
    localparam int P_HCE [2] = '{383, 41};
    localparam int P_HBS [2] = '{256, 30};
    localparam int P_HBE [2] = '{0,   4};
    localparam int P_HSS [2] = '{288, 32};
    localparam int P_HSE [2] = '{320, 35};
    localparam int P_VCS [2] = '{0,   1};
    localparam int P_VCE [2] = '{263, 20};
    localparam int P_VBS [2] = '{240, 17};
    localparam int P_VBE [2] = '{16,  3};
    localparam int P_VSS [2] = '{248, 18};
    localparam int P_VSE [2] = '{251, 20};

    logic [8:0] h0, vd0, vr0, vr10, h1, vd1, vr1, vr11;
    logic hi0, vi0, lh0, lv0, hs0, vs0, hi1, vi1, lh1, lv1, hs1, vs1;

    jtframe_vtimer u0 (
        .clk(clk), .rst_n(rst_n), .pxl_cen(pxl_cen),
        .H(h0), .vdump(vd0), .vrender(vr0), .vrender1(vr10),
        .Hinit(hi0), .Vinit(vi0), .LHBL(lh0), .LVBL(lv0), .HS(hs0), .VS(vs0)
    );

    jtframe_vtimer #(
        .HCNT_START(P_HCS[1]), .HCNT_END(P_HCE[1]), .HB_START(P_HBS[1]), .HB_END(P_HBE[1]),
        .HS_START(P_HSS[1]), .HS_END(P_HSE[1]), .VCNT_START(P_VCS[1]), .VCNT_END(P_VCE[1]),
        .VB_START(P_VBS[1]), .VB_END(P_VBE[1]), .VS_START(P_VSS[1]), .VS_END(P_VSE[1])
    ) u1 (
        .clk(clk), .rst_n(rst_n), .pxl_cen(pxl_cen),
        .H(h1), .vdump(vd1), .vrender(vr1), .vrender1(vr11),
        .Hinit(hi1), .Vinit(vi1), .LHBL(lh1), .LVBL(lv1), .HS(hs1), .VS(vs1)
    );

    logic [8:0] d_h [2], d_vd [2], d_vr [2], d_vr1 [2];
    logic       d_hi [2], d_vi [2], d_lh [2], d_lv [2], d_hs [2], d_vs [2];
    assign d_h[0] = h0;   assign d_vd[0] = vd0; assign d_vr[0] = vr0; assign d_vr1[0] = vr10;
    assign d_h[1] = h1;   assign d_vd[1] = vd1; assign d_vr[1] = vr1; assign d_vr1[1] = vr11;
    assign d_hi[0] = hi0; assign d_vi[0] = vi0; assign d_lh[0] = lh0; assign d_lv[0] = lv0;
    assign d_hs[0] = hs0; assign d_vs[0] = vs0;
    assign d_hi[1] = hi1; assign d_vi[1] = vi1; assign d_lh[1] = lh1; assign d_lv[1] = lv1;
    assign d_hs[1] = hs1; assign d_vs[1] = vs1;

    int checks = 0;
    int fails  = 0;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            fails++;
            if (fails <= 40) $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    // ---------------- behavioural model ----------------
    function automatic int hlen(int i); return P_HCE[i] - P_HCS[i] + 1; endfunction
    function automatic int vlen(int i); return P_VCE[i] - P_VCS[i] + 1; endfunction

    // x lies in the cyclic window starting at s and ending just before e.
    function automatic bit win(int x, int s, int e, int len);
        return ((x - s + len) % len) < ((e - s + len) % len);
    endfunction

    function automatic int step_h(int i, int h);
        return P_HCS[i] + (h - P_HCS[i] + 1) % hlen(i);
    endfunction

    function automatic int step_v(int i, int h, int v);
        if (h != P_HCE[i]) return v;
        return P_VCS[i] + (v - P_VCS[i] + 1) % vlen(i);
    endfunction

    function automatic int vplus(int i, int v, int k);
        return P_VCS[i] + (v - P_VCS[i] + k) % vlen(i);
    endfunction

    int m_h [2], m_v [2];
    bit m_run [2], m_lvbl [2], m_vs [2];

    // Model state advances once per enabled clk edge; reset is asynchronous like the DUT's.
    always @(posedge clk or negedge rst_n) begin
        for (int i = 0; i < 2; i++) begin
            if (!rst_n) begin
                m_h[i]    <= P_HCS[i];
                m_v[i]    <= P_VCS[i];
                m_run[i]  <= 1'b0;
                m_lvbl[i] <= 1'b0;
                m_vs[i]   <= 1'b0;
            end else if (pxl_cen) begin
                m_h[i]   <= step_h(i, m_h[i]);
                m_v[i]   <= step_v(i, m_h[i], m_v[i]);
                m_run[i] <= 1'b1;
                if (step_h(i, m_h[i]) == P_HBS[i]) begin
                    m_lvbl[i] <= !win(step_v(i, m_h[i], m_v[i]), P_VBS[i], P_VBE[i], vlen(i));
                    m_vs[i]   <= win(step_v(i, m_h[i], m_v[i]), P_VSS[i], P_VSE[i], vlen(i));
                end
            end
        end
    end

    // Every falling edge: compare all outputs of both instances against the model.
    always @(negedge clk) begin
        if (chk_en) begin
            for (int i = 0; i < 2; i++) begin
                chk($sformatf("u%0d.H", i),        int'(d_h[i]),   m_h[i]);
                chk($sformatf("u%0d.vdump", i),    int'(d_vd[i]),  m_v[i]);
                chk($sformatf("u%0d.vrender", i),  int'(d_vr[i]),  vplus(i, m_v[i], 1));
                chk($sformatf("u%0d.vrender1", i), int'(d_vr1[i]), vplus(i, m_v[i], 2));
                chk($sformatf("u%0d.Hinit", i),    int'(d_hi[i]),  int'(m_h[i] == P_HCE[i]));
                chk($sformatf("u%0d.Vinit", i),    int'(d_vi[i]),  int'(m_h[i] == P_HCE[i] && m_v[i] == P_VCE[i]));
                chk($sformatf("u%0d.LHBL", i),     int'(d_lh[i]),
                    int'(m_run[i] && !win(m_h[i], P_HBS[i], P_HBE[i], hlen(i))));
                chk($sformatf("u%0d.HS", i),       int'(d_hs[i]),
                    int'(m_run[i] && win(m_h[i], P_HSS[i], P_HSE[i], hlen(i))));
                chk($sformatf("u%0d.LVBL", i),     int'(d_lv[i]),  int'(m_lvbl[i]));
                chk($sformatf("u%0d.VS", i),       int'(d_vs[i]),  int'(m_vs[i]));
            end
        end
    end

    // ---------------- stimulus and literal expectations ----------------
    int  first_hinit, h_at, hs_n, lhbl_low;
    int  hc0, hc1, vc1;
    bit  frozen, reached;

    initial begin
        repeat (3) @(posedge clk);
        #2;
        chk_en = 1'b1;

        // Reset values.
        @(negedge clk);
        chk("rst.H", int'(h0), 0);
        chk("rst.vdump", int'(vd0), 0);
        chk("rst.vrender", int'(vr0), 1);
        chk("rst.vrender1", int'(vr10), 2);
        chk("rst.LHBL", int'(lh0), 0);
        chk("rst.LVBL", int'(lv0), 0);
        chk("rst.HS", int'(hs0), 0);
        chk("rst.VS", int'(vs0), 0);
        chk("rst.Hinit", int'(hi0), 0);
        chk("rst.Vinit", int'(vi0), 0);
        chk("rst.u1.H", int'(h1), 2);
        chk("rst.u1.vrender1", int'(vr11), 3);

        @(posedge clk);
        #2;
        rst_n = 1'b1;

        // One line with pxl_cen every 4th clk.
        first_hinit = -1; h_at = -1; hs_n = 0; lhbl_low = 0;
        for (int n = 1; n <= 384; n++) begin
            pxl_cen = 1'b1;
            @(posedge clk);
            #2;
            pxl_cen = 1'b0;
            if (hi0 && first_hinit < 0) begin
                first_hinit = n;
                h_at = int'(h0);
            end
            if (hs0) hs_n++;
            if (!lh0) lhbl_low++;
            repeat (3) @(posedge clk);
            #2;
        end
        chk("line.first_hinit_cen", first_hinit, 383);
        chk("line.H_at_hinit", h_at, 383);
        chk("line.HS_width", hs_n, 32);
        chk("line.LHBL_low", lhbl_low, 128);
        chk("line.H_after", int'(h0), 0);
        chk("line.vdump_after", int'(vd0), 1);
        chk("line.vrender_after", int'(vr0), 2);

        // Random pxl_cen, a long freeze mid-line, run to vdump=100,H=200.
        frozen = 1'b0; reached = 1'b0;
        for (int c = 0; c < 60000 && !reached; c++) begin
            if (h0 == 9'd200 && vd0 == 9'd100) begin
                reached = 1'b1;
            end else if (!frozen && h0 == 9'd150 && vd0 == 9'd20) begin
                pxl_cen = 1'b0;
                repeat (1000) @(posedge clk);
                #2;
                frozen = 1'b1;
                chk("freeze.H", int'(h0), 150);
                chk("freeze.vdump", int'(vd0), 20);
                chk("freeze.vrender", int'(vr0), 21);
            end else begin
                pxl_cen = ($urandom_range(0, 9) != 0);
                @(posedge clk);
                #2;
            end
        end
        chk("run.frozen", int'(frozen), 1);
        chk("run.reached_v100_h200", int'(reached), 1);

        // Asynchronous reset mid-frame.
        pxl_cen = 1'b0;
        rst_n   = 1'b0;
        #1;
        chk("arst.H", int'(h0), 0);
        chk("arst.vdump", int'(vd0), 0);
        chk("arst.vrender", int'(vr0), 1);
        chk("arst.vrender1", int'(vr10), 2);
        chk("arst.LHBL", int'(lh0), 0);
        chk("arst.LVBL", int'(lv0), 0);
        chk("arst.HS", int'(hs0), 0);
        chk("arst.Hinit", int'(hi0), 0);
        chk("arst.u1.H", int'(h1), 2);
        repeat (3) @(posedge clk);
        #2;
        rst_n = 1'b1;
        @(posedge clk);
        #2;
        chk("arst.H_hold", int'(h0), 0);

        // 800 consecutive pxl_cen: one full small frame, a bit over two default lines.
        hc0 = 0; hc1 = 0; vc1 = 0;
        pxl_cen = 1'b1;
        for (int n = 1; n <= 800; n++) begin
            @(posedge clk);
            #2;
            if (hi0) hc0++;
            if (hi1) hc1++;
            if (vi1) vc1++;
        end
        pxl_cen = 1'b0;
        chk("cen_high.u0.Hinit_count", hc0, 2);
        chk("cen_high.u1.Hinit_count", hc1, 20);
        chk("cen_high.u1.Vinit_count", vc1, 1);
        chk("cen_high.u0.H", int'(h0), 32);
        chk("cen_high.u0.vdump", int'(vd0), 2);
        chk("cen_high.u1.H", int'(h1), 2);
        chk("cen_high.u1.vdump", int'(vd1), 1);

        repeat (5) @(posedge clk);
        $display("%0d/%0d checks passed", checks - fails, checks);
        $finish;
    end

endmodule
